// File: rtl/pipe_adder283.sv
// pipe_adder283: pipelined carry-lookahead adder/subtractor.
// One 4-bit lookahead slice per stage; the carry between slices is registered,
// upper operand bits ride along in skew registers and finished low sum bits
// travel forward with the word. A single global enable stalls every stage.
module pipe_adder283 #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf
);

  localparam int N = W / 4;

  // 4-bit carry-lookahead slice: returns {carry_out, sum[3:0]}
  function automatic logic [4:0] cla4(input logic [3:0] x,
                                      input logic [3:0] y,
                                      input logic       c);
    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] hs;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       c4;
    g  = x & y;
    p  = x | y;
    hs = ~g & p;
    c1 = g[0] | (p[0] & c);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & c);
    return {c4, hs ^ {c3, c2, c1, c}};
  endfunction

  logic         en;
  logic         accept;
  logic [W-1:0] b_eff;
  logic         c0;

  // The whole pipe moves together unless a finished result is waiting
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;
  assign accept   = in_valid & en;

  // Subtraction is addition of the inverted operand with an inverted carry-in
  assign b_eff = sub ? ~b : b;
  assign c0    = cin ^ sub;

  for (genvar k = 0; k < N; k++) begin : g_stage
    logic           valid_r;
    logic           carry_r;
    logic [4*k+3:0] sum_r;
    logic [4*k+3:0] sum_d;
    logic [3:0]     op_a;
    logic [3:0]     op_b;
    logic           op_c;
    logic           op_v;
    logic [4:0]     res;

    if (k == 0) begin : g_src
      assign op_a  = a[3:0];
      assign op_b  = b_eff[3:0];
      assign op_c  = c0;
      assign op_v  = accept;
      assign sum_d = res[3:0];
    end else begin : g_src
      assign op_a  = g_stage[k-1].g_skew.a_r[3:0];
      assign op_b  = g_stage[k-1].g_skew.b_r[3:0];
      assign op_c  = g_stage[k-1].carry_r;
      assign op_v  = g_stage[k-1].valid_r;
      assign sum_d = {res[3:0], g_stage[k-1].sum_r};
    end

    assign res = cla4(op_a, op_b, op_c);

    // Capture this slice's carry, the grown sum word and the slot's valid bit
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        valid_r <= 1'b0;
        carry_r <= 1'b0;
        sum_r   <= '0;
      end else if (en) begin
        valid_r <= op_v;
        carry_r <= res[4];
        sum_r   <= sum_d;
      end
    end

    if (k < N - 1) begin : g_skew
      logic [W-4*k-5:0] a_r;
      logic [W-4*k-5:0] b_r;
      logic [W-4*k-5:0] a_d;
      logic [W-4*k-5:0] b_d;

      if (k == 0) begin : g_first
        assign a_d = a[W-1:4];
        assign b_d = b_eff[W-1:4];
      end else begin : g_next
        assign a_d = g_stage[k-1].g_skew.a_r[W-4*k-1:4];
        assign b_d = g_stage[k-1].g_skew.b_r[W-4*k-1:4];
      end

      // Delay the not-yet-used upper operand bits until their slice's stage
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          a_r <= '0;
          b_r <= '0;
        end else if (en) begin
          a_r <= a_d;
          b_r <= b_d;
        end
      end
    end

    if (k == N - 1) begin : g_last
      logic ovf_r;
      logic carry_top_in;

      // Carry into the top bit is recovered as sum ^ a ^ b' of that bit
      assign carry_top_in = res[3] ^ op_a[3] ^ op_b[3];

      // Signed overflow: carry into the MSB disagrees with carry out of it
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          ovf_r <= 1'b0;
        end else if (en) begin
          ovf_r <= carry_top_in ^ res[4];
        end
      end
    end
  end

  assign out_valid = g_stage[N-1].valid_r;
  assign sum       = g_stage[N-1].sum_r;
  assign cout      = g_stage[N-1].carry_r;
  assign ovf       = g_stage[N-1].g_last.ovf_r;

endmodule

// File: tb/tb_pipe_adder283.sv
// tb_pipe_adder283: drives W=4, W=16 and W=32 instances with shared stimulus
// and checks each against a queue-based arithmetic reference model.
module tb_pipe_adder283;

  localparam int WD [3] = '{4, 16, 32};

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    int          age;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        in_valid;
  logic        out_ready;
  logic        cin;
  logic        sub;
  logic [31:0] a_in;
  logic [31:0] b_in;

  logic        rdy4, rdy16, rdy32;
  logic        ov4, ov16, ov32;
  logic [3:0]  sum4;
  logic [15:0] sum16;
  logic [31:0] sum32;
  logic        co4, co16, co32;
  logic        of4, of16, of32;

  logic        rdy  [3];
  logic        dov  [3];
  logic        dco  [3];
  logic        dovf [3];
  logic [31:0] dsum [3];

  int   total = 0;
  int   bad   = 0;
  exp_t mq [3][$];
  vec_t vecs [7];

  always #5 CLK = ~CLK;

  pipe_adder283 #(.W(4)) u4 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(rdy4),
    .a(a_in[3:0]), .b(b_in[3:0]), .cin(cin), .sub(sub),
    .out_valid(ov4), .out_ready(out_ready), .sum(sum4), .cout(co4), .ovf(of4)
  );

  pipe_adder283 #(.W(16)) u16 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(rdy16),
    .a(a_in[15:0]), .b(b_in[15:0]), .cin(cin), .sub(sub),
    .out_valid(ov16), .out_ready(out_ready), .sum(sum16), .cout(co16), .ovf(of16)
  );

  pipe_adder283 #(.W(32)) u32 (
    .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(rdy32),
    .a(a_in), .b(b_in), .cin(cin), .sub(sub),
    .out_valid(ov32), .out_ready(out_ready), .sum(sum32), .cout(co32), .ovf(of32)
  );

  assign rdy[0]  = rdy4;           assign rdy[1]  = rdy16;          assign rdy[2]  = rdy32;
  assign dov[0]  = ov4;            assign dov[1]  = ov16;           assign dov[2]  = ov32;
  assign dco[0]  = co4;            assign dco[1]  = co16;           assign dco[2]  = co32;
  assign dovf[0] = of4;            assign dovf[1] = of16;           assign dovf[2] = of32;
  assign dsum[0] = {28'h0, sum4};  assign dsum[1] = {16'h0, sum16}; assign dsum[2] = sum32;

  // Width-generic arithmetic reference: plain add, signed overflow by sign rule
  function automatic exp_t model(input int w, input logic [31:0] av,
                                 input logic [31:0] bv, input logic c, input logic s);
    exp_t        e;
    logic [31:0] mask;
    logic [32:0] full;
    logic        sa, sb, ss;
    mask   = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    if (s) full = {1'b0, av & mask} + {1'b0, ~bv & mask} + {32'h0, ~c};
    else   full = {1'b0, av & mask} + {1'b0, bv & mask} + {32'h0, c};
    e.sum  = full[31:0] & mask;
    e.cout = full[w];
    sa     = av[w-1];
    sb     = bv[w-1];
    ss     = e.sum[w-1];
    e.ovf  = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    e.age  = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] av, input logic [31:0] bv,
                               input logic c, input logic s);
    in_valid = v;
    a_in     = av;
    b_in     = bv;
    cin      = c;
    sub      = s;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic checkOutput(input string nm, input logic [15:0] s, input logic co, input logic ov);
    chk({nm, "_sum"},  dsum[1], {16'h0, s});
    chk({nm, "_cout"}, {31'h0, dco[1]}, {31'h0, co});
    chk({nm, "_ovf"},  {31'h0, dovf[1]}, {31'h0, ov});
  endtask

  // One directed pair through an empty pipe: literal result and per-width latency
  task automatic runVector(input vec_t v, input string nm);
    int lat;
    int seen [3];
    for (int d = 0; d < 3; d++) seen[d] = 0;
    @(posedge CLK); #1;
    applyStimulus(1'b1, {16'h0, v.a}, {16'h0, v.b}, v.cin, v.sub);
    @(posedge CLK); #1;
    applyIdle();
    lat = 1;
    while ((seen[0] == 0 || seen[1] == 0 || seen[2] == 0) && lat < 12) begin
      for (int d = 0; d < 3; d++) begin
        if (seen[d] == 0 && dov[d]) begin
          seen[d] = lat;
          if (d == 1) checkOutput(nm, v.s, v.co, v.ov);
        end
      end
      if (seen[0] == 0 || seen[1] == 0 || seen[2] == 0) begin
        @(posedge CLK); #1;
        lat++;
      end
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s_latency_w%0d", nm, WD[d]), seen[d], WD[d] / 4);
  endtask

  // Reference model: each instance is a FIFO whose entries need N enabled edges
  logic hv_m, en_m;
  exp_t e_m;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int d = 0; d < 3; d++) mq[d].delete();
    end else begin
      for (int d = 0; d < 3; d++) begin
        hv_m = (mq[d].size() > 0) && (mq[d][0].age == WD[d] / 4);
        en_m = !hv_m || out_ready;
        if (en_m) begin
          if (hv_m) void'(mq[d].pop_front());
          for (int i = 0; i < mq[d].size(); i++) mq[d][i].age = mq[d][i].age + 1;
          if (in_valid) begin
            e_m     = model(WD[d], a_in, b_in, cin, sub);
            e_m.age = 1;
            mq[d].push_back(e_m);
          end
        end
      end
    end
  end

  // Compare every instance against the model once per cycle, away from the edge
  logic hv_c;
  exp_t h_c;
  always @(negedge CLK) begin
    if (RST_N) begin
      for (int d = 0; d < 3; d++) begin
        hv_c = (mq[d].size() > 0) && (mq[d][0].age == WD[d] / 4);
        chk($sformatf("out_valid_w%0d", WD[d]), {31'h0, dov[d]}, {31'h0, hv_c});
        chk($sformatf("in_ready_w%0d", WD[d]), {31'h0, rdy[d]}, {31'h0, (!hv_c || out_ready)});
        if (hv_c) begin
          h_c = mq[d][0];
          chk($sformatf("sum_w%0d", WD[d]), dsum[d], h_c.sum);
          chk($sformatf("cout_w%0d", WD[d]), {31'h0, dco[d]}, {31'h0, h_c.cout});
          chk($sformatf("ovf_w%0d", WD[d]), {31'h0, dovf[d]}, {31'h0, h_c.ovf});
        end
      end
    end
  end

  // Hard time limit so the bench always ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed and random sequence
  initial begin
    int          sent;
    int          got;
    logic        acc;
    logic [31:0] held_sum;
    logic [1:0]  held_flags;
    exp_t        pin;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[4] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[5] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[6] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b1, 1'b0};

    RST_N     = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_out_valid_w%0d", WD[d]), {31'h0, dov[d]}, 32'h0);
      chk($sformatf("reset_sum_w%0d", WD[d]), dsum[d], 32'h0);
      chk($sformatf("reset_cout_w%0d", WD[d]), {31'h0, dco[d]}, 32'h0);
      chk($sformatf("reset_ovf_w%0d", WD[d]), {31'h0, dovf[d]}, 32'h0);
      chk($sformatf("reset_in_ready_w%0d", WD[d]), {31'h0, rdy[d]}, 32'h1);
    end

    pin = model(16, 32'h7FFF, 32'h0001, 1'b0, 1'b0);
    chk("model_pin_ovf16", {pin.sum[15:0], 14'h0, pin.cout, pin.ovf}, {16'h8000, 16'h0001});
    pin = model(4, 32'hF, 32'h1, 1'b0, 1'b1);
    chk("model_pin_sub4", {pin.sum[15:0], 14'h0, pin.cout, pin.ovf}, {16'h000E, 16'h0002});
    pin = model(32, 32'h8000_0000, 32'h1, 1'b0, 1'b1);
    chk("model_pin_sub32", pin.sum, 32'h7FFF_FFFF);
    chk("model_pin_flags32", {30'h0, pin.cout, pin.ovf}, 32'h3);

    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;

    for (int i = 0; i < 7; i++) runVector(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back stream with a three-edge stall in the middle
    sent = 0;
    got  = 0;
    held_sum   = '0;
    held_flags = '0;
    @(posedge CLK); #1;
    applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge CLK);
      acc = in_valid && rdy16;
      if (dov[1] && out_ready) got++;
      if (!out_ready) begin
        chk("stall_in_ready", {31'h0, rdy16}, 32'h0);
        chk("stall_out_valid", {31'h0, dov[1]}, 32'h1);
        chk("stall_sum_hold", dsum[1], held_sum);
        chk("stall_flags_hold", {30'h0, dco[1], dovf[1]}, {30'h0, held_flags});
      end
      @(posedge CLK); #1;
      if (acc) sent++;
      if (cyc == 5) begin
        out_ready  = 1'b0;
        held_sum   = dsum[1];
        held_flags = {dco[1], dovf[1]};
      end else if (cyc == 8) begin
        out_ready = 1'b1;
      end
      if (sent >= 8) applyIdle();
      else if (acc) applyStimulus(1'b1, $urandom, $urandom,
                                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    chk("bp_accepted", sent, 8);
    chk("bp_results", got, 8);

    // Reset with three words in flight
    @(posedge CLK); #1;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      @(posedge CLK); #1;
    end
    applyIdle();
    RST_N = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midrst_valid_w%0d", WD[d]), {31'h0, dov[d]}, 32'h0);
      chk($sformatf("midrst_sum_w%0d", WD[d]), dsum[d], 32'h0);
      chk($sformatf("midrst_flags_w%0d", WD[d]), {30'h0, dco[d], dovf[d]}, 32'h0);
    end
    @(posedge CLK); #1;
    RST_N = 1'b1;
    repeat (10) begin
      @(negedge CLK);
      for (int d = 0; d < 3; d++)
        chk($sformatf("midrst_no_ghost_w%0d", WD[d]), {31'h0, dov[d]}, 32'h0);
    end
    runVector(vecs[0], "after_reset");

    // Random add/sub traffic with bubbles and stalls
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge CLK); #1;
      out_ready = ($urandom_range(0, 4) != 0);
      applyStimulus(($urandom_range(0, 3) != 0), $urandom, $urandom,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    @(posedge CLK); #1;
    out_ready = 1'b1;
    applyIdle();
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    for (int d = 0; d < 3; d++)
      chk($sformatf("drained_w%0d", WD[d]), {31'h0, dov[d]}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
